// File: rtl/spu_pkg.sv
// Shared definitions for the SPU-style core: opcode encodings, instruction field
// positions (big-endian numbering, bit 0 = MSB), decoded operation classes, helpers.
package spu_pkg;

    localparam int IM_DEPTH = 1024;
    localparam int RF_DEPTH = 128;
    localparam int LS_LINES = 2048;

    // RR-format opcodes (11 bits)
    localparam logic [10:0] OPC_A    = 11'b00011000000;
    localparam logic [10:0] OPC_SF   = 11'b00001000000;
    localparam logic [10:0] OPC_AND  = 11'b00011000001;
    localparam logic [10:0] OPC_OR   = 11'b00001000001;
    localparam logic [10:0] OPC_XOR  = 11'b01001000001;
    localparam logic [10:0] OPC_STOP = 11'b00000000000;
    localparam logic [10:0] OPC_LNOP = 11'b00000000001;
    localparam logic [10:0] OPC_NOP  = 11'b01000000001;

    // RI16-format opcodes (9 bits)
    localparam logic [8:0] OPC_IL   = 9'b010000001;
    localparam logic [8:0] OPC_BR   = 9'b001100100;
    localparam logic [8:0] OPC_BRNZ = 9'b001000010;

    // RI10-format opcodes (8 bits)
    localparam logic [7:0] OPC_AI   = 8'b00011100;
    localparam logic [7:0] OPC_LQD  = 8'b00110100;
    localparam logic [7:0] OPC_STQD = 8'b00100100;

    localparam int OP11_FIRST = 0;
    localparam int OP11_LAST  = 10;
    localparam int OP9_LAST   = 8;
    localparam int OP8_LAST   = 7;
    localparam int RB_FIRST   = 11;
    localparam int RB_LAST    = 17;
    localparam int RA_FIRST   = 18;
    localparam int RA_LAST    = 24;
    localparam int RT_FIRST   = 25;
    localparam int RT_LAST    = 31;
    localparam int I10_FIRST  = 8;
    localparam int I10_LAST   = 17;
    localparam int I16_FIRST  = 9;
    localparam int I16_LAST   = 24;

    typedef enum logic [3:0] {
        OP_NOP, OP_A, OP_SF, OP_AND, OP_OR, OP_XOR, OP_STOP,
        OP_AI, OP_LQD, OP_STQD, OP_IL, OP_BR, OP_BRNZ
    } op_class_e;

    typedef enum logic {ST_RUN, ST_HALT} core_state_e;

    function automatic logic [31:0] sext10(input logic [9:0] v);
        return {{22{v[9]}}, v};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/spu_alu_if.sv
// Operand/result bundle between the core's decode stage and the execute unit.
interface spu_alu_if;
    import spu_pkg::*;

    op_class_e    op;
    logic [0:127] ra;
    logic [0:127] rb;
    logic [0:127] rt;
    logic [31:0]  imm;
    logic [0:127] result;
    logic         br_taken;

    modport master (output op, ra, rb, rt, imm, input result, br_taken);
    modport slave  (input op, ra, rb, rt, imm, output result, br_taken);
endinterface

// File: rtl/spu_alu.sv
// Combinational execute unit: per-word arithmetic, 128-bit logic ops, immediate
// splat and branch-taken evaluation.
module spu_alu
    import spu_pkg::*;
(
    spu_alu_if.slave bus
);

    logic [0:127] res;
    logic         taken;
    logic         unused_rt;

    assign unused_rt = ^bus.rt[32:127];

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        res   = '0;
        taken = 1'b0;
        for (int w = 0; w < 4; w++) begin
            case (bus.op)
                OP_A:    res[32*w +: 32] = bus.ra[32*w +: 32] + bus.rb[32*w +: 32];
                OP_SF:   res[32*w +: 32] = bus.rb[32*w +: 32] - bus.ra[32*w +: 32];
                OP_AI:   res[32*w +: 32] = bus.ra[32*w +: 32] + bus.imm;
                OP_IL:   res[32*w +: 32] = bus.imm;
                default: ;
            endcase
        end
        case (bus.op)
            OP_AND:  res   = bus.ra & bus.rb;
            OP_OR:   res   = bus.ra | bus.rb;
            OP_XOR:  res   = bus.ra ^ bus.rb;
            OP_BR:   taken = 1'b1;
            OP_BRNZ: taken = |bus.rt[0:31];
            default: ;
        endcase
    end

    assign bus.result   = res;
    assign bus.br_taken = taken;

endmodule

// File: rtl/top_level.sv
// Single-issue SPU-style core: memories, decode, PC/halt control and preload ports.
// One instruction retires per unstalled cycle; results are visible to the next one.
module top_level
    import spu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [0:31]  instruction_in,
    input  logic [0:9]   instr_load_addr,
    input  logic         preload_en,
    input  logic [0:9]   preload_addr,
    input  logic [0:127] preload_values,
    input  logic         preload_LS_en,
    input  logic [0:14]  preload_LS_addr,
    input  logic [0:127] preload_LS_data,
    output logic         halted
);

    logic [0:31]  im_q [0:IM_DEPTH-1];
    logic [0:127] rf_q [0:RF_DEPTH-1];
    logic [0:127] ls_q [0:LS_LINES-1];

    logic [9:0]   pc_q, pc_d;
    core_state_e  state_q, state_d;

    logic [0:31]  instr;
    logic [6:0]   ra_idx, rb_idx, rt_idx;
    logic [9:0]   i10;
    logic [15:0]  i16;
    op_class_e    op_cls;
    logic [31:0]  imm;
    logic         decoded;
    logic [0:127] ra_val, rb_val, rt_val, ls_rd, wb_data;
    logic [31:0]  ls_addr;
    logic [10:0]  ls_line;
    logic         exec, rf_we, ls_we;
    logic         unused_bits;

    spu_alu_if alu_bus ();
    spu_alu u_alu (.bus(alu_bus.slave));

    assign instr  = im_q[pc_q];
    assign rb_idx = instr[RB_FIRST:RB_LAST];
    assign ra_idx = instr[RA_FIRST:RA_LAST];
    assign rt_idx = instr[RT_FIRST:RT_LAST];
    assign i10    = instr[I10_FIRST:I10_LAST];
    assign i16    = instr[I16_FIRST:I16_LAST];

    always_comb begin
        op_cls  = OP_NOP;
        imm     = '0;
        decoded = 1'b1;
        case (instr[OP11_FIRST:OP11_LAST])
            OPC_A:              op_cls = OP_A;
            OPC_SF:             op_cls = OP_SF;
            OPC_AND:            op_cls = OP_AND;
            OPC_OR:             op_cls = OP_OR;
            OPC_XOR:            op_cls = OP_XOR;
            OPC_STOP:           op_cls = OP_STOP;
            OPC_LNOP, OPC_NOP:  op_cls = OP_NOP;
            default:            decoded = 1'b0;
        endcase
        if (!decoded) begin
            decoded = 1'b1;
            imm     = sext16(i16);
            case (instr[OP11_FIRST:OP9_LAST])
                OPC_IL:   op_cls = OP_IL;
                OPC_BR:   op_cls = OP_BR;
                OPC_BRNZ: op_cls = OP_BRNZ;
                default:  decoded = 1'b0;
            endcase
        end
        if (!decoded) begin
            imm = sext10(i10);
            case (instr[OP11_FIRST:OP8_LAST])
                OPC_AI:   op_cls = OP_AI;
                OPC_LQD:  op_cls = OP_LQD;
                OPC_STQD: op_cls = OP_STQD;
                default:  op_cls = OP_NOP;
            endcase
        end
    end

    assign ra_val  = rf_q[ra_idx];
    assign rb_val  = rf_q[rb_idx];
    assign rt_val  = rf_q[rt_idx];
    // Quadword addressing wraps inside the 32 KB store: keep byte-address bits 14:4.
    assign ls_addr = ra_val[0:31] + (imm << 4);
    assign ls_line = ls_addr[14:4];
    assign ls_rd   = ls_q[ls_line];

    assign alu_bus.op  = op_cls;
    assign alu_bus.ra  = ra_val;
    assign alu_bus.rb  = rb_val;
    assign alu_bus.rt  = rt_val;
    assign alu_bus.imm = imm;

    assign exec = rst && (state_q == ST_RUN) && !(load_en || preload_en || preload_LS_en);

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        rf_we   = 1'b0;
        ls_we   = 1'b0;
        wb_data = alu_bus.result;
        if (exec) begin
            pc_d = pc_q + 10'd1;
            case (op_cls)
                OP_STOP: begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
                OP_A, OP_SF, OP_AND, OP_OR, OP_XOR, OP_AI, OP_IL: rf_we = 1'b1;
                OP_LQD: begin
                    rf_we   = 1'b1;
                    wb_data = ls_rd;
                end
                OP_STQD: ls_we = 1'b1;
                OP_BR, OP_BRNZ: if (alu_bus.br_taken) pc_d = pc_q + imm[9:0];
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // NOTE: memories have no reset; their contents must survive reset and preloads land while it is held.
    always_ff @(posedge clk) begin
        if (load_en) im_q[instr_load_addr] <= instruction_in;
    end

    always_ff @(posedge clk) begin
        if (preload_en)  rf_q[preload_addr[3:9]] <= preload_values;
        else if (rf_we)  rf_q[rt_idx] <= wb_data;
    end

    always_ff @(posedge clk) begin
        if (preload_LS_en) ls_q[preload_LS_addr[0:10]] <= preload_LS_data;
        else if (ls_we)    ls_q[ls_line] <= rt_val;
    end

    assign halted = (state_q == ST_HALT);

    assign unused_bits = ^{preload_addr[0:2], preload_LS_addr[11:14],
                           ls_addr[31:15], ls_addr[3:0]};

endmodule

// File: tb/tb_top_level.sv
// Directed self-checking bench for top_level: preload, programs, branches,
// async reset, address wrap, unknown opcode and PC wrap.
module tb_top_level;
    import spu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_en;
    logic [0:31]  instruction_in;
    logic [0:9]   instr_load_addr;
    logic         preload_en;
    logic [0:9]   preload_addr;
    logic [0:127] preload_values;
    logic         preload_LS_en;
    logic [0:14]  preload_LS_addr;
    logic [0:127] preload_LS_data;
    logic         halted;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    top_level dut (
        .clk(clk), .rst(rst), .load_en(load_en), .instruction_in(instruction_in),
        .instr_load_addr(instr_load_addr), .preload_en(preload_en),
        .preload_addr(preload_addr), .preload_values(preload_values),
        .preload_LS_en(preload_LS_en), .preload_LS_addr(preload_LS_addr),
        .preload_LS_data(preload_LS_data), .halted(halted)
    );

    spu_alu_if alu_bus ();
    spu_alu u_alu (.bus(alu_bus.slave));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rr(input logic [10:0] op, input int rb, input int ra, input int rt);
        return {op, 7'(rb), 7'(ra), 7'(rt)};
    endfunction

    function automatic logic [31:0] ri10(input logic [7:0] op, input int i10, input int ra, input int rt);
        return {op, 10'(i10), 7'(ra), 7'(rt)};
    endfunction

    function automatic logic [31:0] ri16(input logic [8:0] op, input int i16, input int rt);
        return {op, 16'(i16), 7'(rt)};
    endfunction

    function automatic logic [127:0] splat(input logic [31:0] w);
        return {4{w}};
    endfunction

    task automatic load_word(input int addr, input logic [31:0] w);
        load_en = 1'b1; instr_load_addr = 10'(addr); instruction_in = w;
        tick();
        load_en = 1'b0;
    endtask

    task automatic preload_reg(input int addr, input logic [127:0] v);
        preload_en = 1'b1; preload_addr = 10'(addr); preload_values = v;
        tick();
        preload_en = 1'b0;
    endtask

    task automatic preload_ls(input int byte_addr, input logic [127:0] v);
        preload_LS_en = 1'b1; preload_LS_addr = 15'(byte_addr); preload_LS_data = v;
        tick();
        preload_LS_en = 1'b0;
    endtask

    task automatic run(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; preload_en = 1'b0; preload_LS_en = 1'b0;
        instruction_in = '0; instr_load_addr = '0; preload_addr = '0;
        preload_values = '0; preload_LS_addr = '0; preload_LS_data = '0;
        #1 rst = 1'b0;
        #1;
        check("reset_pc", dut.pc_q, 0);
        check("reset_halted", halted, 0);

        // Load/add/store program, loaded during reset
        load_word(0, ri16(9'b010000001, 16'h10, 1));
        load_word(1, ri10(8'b00110100, 0, 1, 2));
        load_word(2, rr(11'b00011000000, 2, 2, 3));
        load_word(3, ri10(8'b00100100, 2, 1, 3));
        load_word(4, 32'h0);

        // Simultaneous preloads with the core out of reset must stall the PC
        rst = 1'b1;
        preload_en = 1'b1; preload_addr = 10'd5;
        preload_values = 128'h00000001_00000002_00000003_00000004;
        preload_LS_en = 1'b1; preload_LS_addr = 15'h0010; preload_LS_data = splat(32'h3f800000);
        tick();
        tick();
        check("stall_pc", dut.pc_q, 0);
        check("preload_ls", dut.ls_q[1], splat(32'h3f800000));
        check("preload_rf", dut.rf_q[5], 128'h00000001_00000002_00000003_00000004);
        preload_en = 1'b0;
        preload_LS_addr = 15'h0017;
        preload_LS_data = 128'h00000001_00000002_00000003_00000004;
        tick();
        preload_LS_en = 1'b0;
        check("stall_pc2", dut.pc_q, 0);
        check("ls_low_bits_ignored", dut.ls_q[1], 128'h00000001_00000002_00000003_00000004);

        run(20, cyc);
        check("prog_cycles", cyc, 5);
        check("prog_halted", halted, 1);
        check("prog_pc", dut.pc_q, 4);
        check("prog_lqd_r2", dut.rf_q[2], 128'h00000001_00000002_00000003_00000004);
        check("prog_stqd_ls3", dut.ls_q[3], 128'h00000002_00000004_00000006_00000008);

        load_word(500, 32'h0);
        tick();
        check("halt_sticky", halted, 1);
        check("halt_pc_hold", dut.pc_q, 4);

        // sf / ai / logic ops
        rst = 1'b0;
        #1;
        check("rst_clears_halt", halted, 0);
        check("rst_clears_pc", dut.pc_q, 0);
        load_word(0, rr(11'b00001000000, 2, 1, 3));
        load_word(1, ri10(8'b00011100, -3, 1, 4));
        load_word(2, rr(11'b01001000001, 2, 1, 5));
        load_word(3, rr(11'b00011000001, 2, 1, 6));
        load_word(4, rr(11'b00001000001, 2, 1, 7));
        load_word(5, rr(11'b00000000001, 0, 0, 0));
        load_word(6, rr(11'b01000000001, 0, 0, 0));
        load_word(7, 32'h0);
        preload_reg(1, splat(32'd5));
        preload_reg(10'h382, splat(32'd12));
        rst = 1'b1;
        run(20, cyc);
        check("alu_cycles", cyc, 8);
        check("alu_pc", dut.pc_q, 7);
        check("sf_r3", dut.rf_q[3], splat(32'd7));
        check("ai_r4", dut.rf_q[4], splat(32'd2));
        check("xor_r5", dut.rf_q[5], splat(32'd9));
        check("and_r6", dut.rf_q[6], splat(32'd4));
        check("or_r7", dut.rf_q[7], splat(32'd13));

        // Branch loop
        rst = 1'b0;
        load_word(0, ri16(9'b010000001, 3, 1));
        load_word(1, ri10(8'b00011100, -1, 1, 1));
        load_word(2, ri16(9'b001000010, -1, 1));
        load_word(3, 32'h0);
        rst = 1'b1;
        run(30, cyc);
        check("loop_cycles", cyc, 8);
        check("loop_r1", dut.rf_q[1], 128'h0);
        check("loop_pc", dut.pc_q, 3);

        // Async reset in the middle of a long loop
        rst = 1'b0;
        load_word(0, ri16(9'b010000001, 100, 1));
        rst = 1'b1;
        repeat (5) tick();
        check("midrun_r1", dut.rf_q[1], splat(32'd98));
        #2 rst = 1'b0;
        #1;
        check("async_pc", dut.pc_q, 0);
        check("async_halted", halted, 0);
        tick();
        check("rst_hold_pc", dut.pc_q, 0);
        check("rst_rf_kept", dut.rf_q[1], splat(32'd98));
        check("rst_ls_kept", dut.ls_q[3], 128'h00000002_00000004_00000006_00000008);
        rst = 1'b1;
        tick();
        check("restart_pc", dut.pc_q, 1);
        check("restart_r1", dut.rf_q[1], splat(32'd100));

        // lqd address wrap, unknown opcode, forward br
        rst = 1'b0;
        load_word(0, ri10(8'b00110100, 1, 6, 7));
        load_word(1, 32'hFFFF_FFFF);
        load_word(2, ri16(9'b001100100, 2, 0));
        load_word(3, 32'h0);
        load_word(4, 32'h0);
        preload_reg(6, 128'h00007FF0_00000100_00000100_00000100);
        preload_reg(127, splat(32'ha5a5a5a5));
        preload_ls(0, 128'hdeadbeef_01234567_89abcdef_cafef00d);
        preload_ls(15'h7FF0, splat(32'h11111111));
        rst = 1'b1;
        run(20, cyc);
        check("wrap_cycles", cyc, 4);
        check("wrap_pc", dut.pc_q, 4);
        check("lqd_wrap_r7", dut.rf_q[7], 128'hdeadbeef_01234567_89abcdef_cafef00d);
        check("unknown_r127", dut.rf_q[127], splat(32'ha5a5a5a5));
        check("unknown_ls0", dut.ls_q[0], 128'hdeadbeef_01234567_89abcdef_cafef00d);

        // PC wrap 1023 -> 0
        rst = 1'b0;
        load_word(0, ri16(9'b001100100, -2, 0));
        load_word(1022, rr(11'b01000000001, 0, 0, 0));
        load_word(1023, rr(11'b00000000001, 0, 0, 0));
        rst = 1'b1;
        tick();
        check("br_back_pc", dut.pc_q, 1022);
        tick();
        tick();
        check("pc_wrap", dut.pc_q, 0);

        // Execute unit in isolation
        alu_bus.op = OP_BRNZ; alu_bus.ra = '0; alu_bus.rb = '0; alu_bus.imm = '0;
        alu_bus.rt = 128'h00000000_00000001_00000001_00000001;
        #1;
        check("alu_brnz_w0_zero", alu_bus.br_taken, 0);
        alu_bus.rt = 128'h00000001_00000000_00000000_00000000;
        #1;
        check("alu_brnz_w0_set", alu_bus.br_taken, 1);
        alu_bus.op = OP_SF;
        alu_bus.ra = 128'h00000001_00000005_FFFFFFFF_00000000;
        alu_bus.rb = 128'h00000000_00000007_00000001_00000010;
        #1;
        check("alu_sf_words", alu_bus.result, 128'hFFFFFFFF_00000002_00000002_00000010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
